ps2_scancode_decoder: RTL and testbench

Sits directly downstream of ps2_keyboard and consumes its valid_data/data byte stream (Set 2 scan codes). It folds the E0 (extended), F0 (break) and E1 (Pause) prefix sequences into single key events of the form {extended, released, code}. Events are buffered in a small FIFO with a valid/ready output handshake toward the keymap/host logic.

---
 rtl/ps2_scancode_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Folds the Set 2 scan-code byte stream from ps2_keyboard into single key
//   events {extended, released, code}. E0 (extended), F0 (break) and E1
//   (Pause) prefix sequences are absorbed. Decoded events are queued in a
//   small FIFO that the keymap/host logic drains with a valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH     buffered key events (power of two, >= 2)
//   TIMEOUT_CYCLES cycles allowed after a prefix byte before the partial
//                  sequence is abandoned
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   valid_data   byte strobe from ps2_keyboard (one byte per rising level)
//   data         scan-code byte qualified by valid_data
//   out_valid    event available at FIFO head
//   out_ready    consumer accepts the head event
//   out_code     head event scan code
//   out_extended head event had an E0 prefix (also set for Pause)
//   out_released head event is a break
//   overflow     sticky: an event was dropped because the FIFO was full
//   timeout      one-cycle pulse when a partial sequence is abandoned
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid_data,
    input  logic [7:0] data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_extended,
    output logic       out_released,
    output logic       overflow,
    output logic       timeout
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP_E1
    } state_t;

    state_t state, state_n, cur_state;

    // Input sampling and registered rising-edge detect on valid_data.
    logic       vd_sync;
    logic       vd_prev;
    logic [7:0] data_q;
    logic       accept;

    always_ff @(posedge clock) begin
        if (!reset) begin
            vd_sync <= 1'b0;
            vd_prev <= 1'b0;
            data_q  <= '0;
        end else begin
            vd_sync <= valid_data;
            vd_prev <= vd_sync;
            data_q  <= data;
        end
    end

    assign accept = vd_sync & ~vd_prev;

    // Decoder state.
    logic [2:0]        skip, skip_n;
    logic [TCNT_W-1:0] tcnt;
    logic              tmo_hit;
    logic              emit;
    logic [9:0]        emit_data;
    logic              filtered;
    logic              push_q;
    logic [9:0]        push_data;

    assign tmo_hit  = (state != IDLE) && (tcnt == TCNT_W'(TIMEOUT_CYCLES));
    assign filtered = (data_q == 8'h00) || (data_q == 8'hAA) || (data_q == 8'hEE) ||
                      (data_q == 8'hFA) || (data_q == 8'hFE) || (data_q == 8'hFF);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            skip      <= '0;
            tcnt      <= '0;
            timeout   <= 1'b0;
            push_q    <= 1'b0;
            push_data <= '0;
        end else begin
            state     <= state_n;
            skip      <= skip_n;
            timeout   <= tmo_hit;
            push_q    <= emit;
            push_data <= emit_data;
            if (accept || tmo_hit || state == IDLE)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;
        end
    end

    // A timeout collapses the current state to IDLE first, so a byte landing
    // in the same cycle is decoded in IDLE context.
    always_comb begin
        state_n   = state;
        skip_n    = skip;
        emit      = 1'b0;
        emit_data = '0;
        cur_state = tmo_hit ? IDLE : state;
        if (tmo_hit)
            state_n = IDLE;
        if (accept) begin
            case (cur_state)
                IDLE: begin
                    state_n = IDLE;
                    if (data_q == 8'hF0) begin
                        state_n = GOT_F0;
                    end else if (data_q == 8'hE0) begin
                        state_n = GOT_E0;
                    end else if (data_q == 8'hE1) begin
                        state_n = SKIP_E1;
                        skip_n  = 3'd7;
                    end else if (!filtered) begin
                        emit      = 1'b1;
                        emit_data = {1'b0, 1'b0, data_q};
                    end
                end
                GOT_E0: begin
                    if (data_q == 8'hF0) begin
                        state_n = GOT_E0F0;
                    end else if (data_q == 8'hE0) begin
                        state_n = GOT_E0;
                    end else begin
                        emit      = 1'b1;
                        emit_data = {1'b1, 1'b0, data_q};
                        state_n   = IDLE;
                    end
                end
                GOT_F0: begin
                    emit      = 1'b1;
                    emit_data = {1'b0, 1'b1, data_q};
                    state_n   = IDLE;
                end
                GOT_E0F0: begin
                    emit      = 1'b1;
                    emit_data = {1'b1, 1'b1, data_q};
                    state_n   = IDLE;
                end
                SKIP_E1: begin
                    if (skip == 3'd1) begin
                        emit      = 1'b1;
                        emit_data = {1'b1, 1'b0, 8'hE1};
                        state_n   = IDLE;
                        skip_n    = '0;
                    end else begin
                        skip_n  = skip - 1'b1;
                        state_n = SKIP_E1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Event FIFO.
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = out_valid && out_ready;
    assign push_ok = push_q && (!full || pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_q && !push_ok)
                overflow <= 1'b1;
        end
    end

    assign out_valid = (count != '0);
    assign {out_extended, out_released, out_code} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder. Expected events are queued as bytes are
// issued; an independent monitor pops and compares each event the DUT hands
// over. Status outputs are checked directly from the stimulus process.
module tb_ps2_scancode_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid_data;
    logic [7:0] data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_extended;
    logic       out_released;
    logic       overflow;
    logic       timeout;

    int checks = 0;
    int passes = 0;
    int tmo_pulses = 0;
    logic [9:0] exp_q[$];

    ps2_scancode_decoder #(
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .valid_data(valid_data),
        .data(data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code(out_code),
        .out_extended(out_extended),
        .out_released(out_released),
        .overflow(overflow),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rise.
    always @(negedge clock) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: got %h expected none",
                         {out_extended, out_released, out_code});
            end else begin
                check("event", {out_extended, out_released, out_code}, exp_q.pop_front());
            end
        end
        if (reset === 1'b1 && timeout === 1'b1)
            tmo_pulses++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        data       = b;
        valid_data = 1'b1;
        repeat (3) @(posedge clock);
        #1 valid_data = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic expect_ev(input logic [9:0] ev);
        exp_q.push_back(ev);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && out_valid === 1'b0)
                break;
        end
        check({name, "_pending"}, 10'(exp_q.size()), 10'd0);
        check({name, "_out_valid"}, {9'd0, out_valid}, 10'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        reset      = 1'b0;
        valid_data = 1'b0;
        data       = 8'h00;
        out_ready  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", {9'd0, out_valid}, 10'd0);
        check("rst_head", {out_extended, out_released, out_code}, 10'h000);
        check("rst_overflow", {9'd0, overflow}, 10'd0);
        check("rst_timeout", {9'd0, timeout}, 10'd0);
        @(posedge clock); #1 reset = 1'b1;

        // Make then break.
        expect_ev(10'h01C); send_byte(8'h1C);
        expect_ev(10'h11C); send_byte(8'hF0); send_byte(8'h1C);
        wait_drain("basic");
        check("basic_overflow", {9'd0, overflow}, 10'd0);
        check("basic_timeout_pulses", 10'(tmo_pulses), 10'd0);

        // Extended make/break with filtered bytes in between.
        expect_ev(10'h275); send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hAA); send_byte(8'hFA);
        expect_ev(10'h375); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        wait_drain("ext");

        // Pause sequence becomes one event.
        expect_ev(10'h2E1);
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        expect_ev(10'h01C); send_byte(8'h1C);
        wait_drain("pause");

        // Abandoned break prefix.
        t0 = tmo_pulses;
        send_byte(8'hF0);
        repeat (150) @(posedge clock);
        @(negedge clock);
        check("timeout_pulses", 10'(tmo_pulses - t0), 10'd1);
        check("timeout_no_event", {9'd0, out_valid}, 10'd0);
        expect_ev(10'h01C); send_byte(8'h1C);
        wait_drain("after_timeout");

        // FIFO fill and overflow.
        out_ready = 1'b0;
        expect_ev(10'h015); send_byte(8'h15);
        expect_ev(10'h01D); send_byte(8'h1D);
        expect_ev(10'h024); send_byte(8'h24);
        expect_ev(10'h02D); send_byte(8'h2D);
        send_byte(8'h2C); send_byte(8'h35);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("ovf_flag", {9'd0, overflow}, 10'd1);
        check("ovf_valid", {9'd0, out_valid}, 10'd1);
        check("ovf_head_hold", {out_extended, out_released, out_code}, 10'h015);
        @(posedge clock); #1 out_ready = 1'b1;
        wait_drain("ovf");

        // Reset mid-sequence with events queued.
        out_ready = 1'b0;
        send_byte(8'h1C); send_byte(8'h32); send_byte(8'hE0);
        @(negedge clock);
        check("pre_rst_valid", {9'd0, out_valid}, 10'd1);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_valid", {9'd0, out_valid}, 10'd0);
        check("mid_rst_overflow", {9'd0, overflow}, 10'd0);
        @(posedge clock); #1 reset = 1'b1; out_ready = 1'b1;
        expect_ev(10'h075); send_byte(8'h75);
        wait_drain("after_reset");

        check("final_pending", 10'(exp_q.size()), 10'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
